mem_access_unit: RTL and testbench

- Parametrised, handshaked load/store unit between the CPU pipeline and a word-wide RAM port with variable latency.
- Aligns store data onto byte lanes and generates byte enables. Extracts and sign/zero-extends load data.
- Unlike the single-cycle controller, it registers requests, waits for RAM acknowledge, and splits word-crossing misaligned accesses into two RAM transactions.

---
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Handshaked load/store unit: registers a CPU request, drives one or two
// word-wide RAM transactions (splitting word-crossing accesses), waits for
// the RAM acknowledge, and returns one response pulse with extended load data.
module mem_access_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MISALIGNED_EN = 1,
  localparam int BYTES        = DATA_WIDTH / 8,
  localparam int LEN_W        = $clog2(BYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [LEN_W-1:0]      req_length,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_fault,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  ram_req,
  output logic                  ram_store,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [BYTES-1:0]      ram_byte_select,
  input  logic                  ram_ack,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state, state_nx;

  logic                    r_store, r_unsigned, r_fault;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_W-1:0]        r_len;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [2*DATA_WIDTH-1:0] rbuf;   // low half = first word, high half = next word

  logic                    accept, illegal, split;
  logic [LEN_W:0]          size_in, sum;
  logic [LEN_W-1:0]        r_off;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [BYTES-1:0]        lmask;
  logic [DATA_WIDTH-1:0]   wmask, shifted_lo, ld_data;
  logic [2*BYTES-1:0]      wide_sel;
  logic [2*DATA_WIDTH-1:0] wide_dat;
  logic                    sign;

  assign accept  = req_valid && (state == IDLE);
  // Size must be a power of two; optionally demand natural alignment too.
  assign size_in = {1'b0, req_length} + {{LEN_W{1'b0}}, 1'b1};
  assign illegal = ((size_in & {1'b0, req_length}) != '0) ||
                   ((MISALIGNED_EN == 0) && ((req_address[LEN_W-1:0] & req_length) != '0));

  assign r_off     = r_addr[LEN_W-1:0];
  assign sum       = {1'b0, r_off} + {1'b0, r_len};
  assign split     = sum[LEN_W];   // last byte lands past the current word
  assign word_addr = {r_addr[ADDR_WIDTH-1:LEN_W], {LEN_W{1'b0}}};

  // State register; async reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)  state_nx = illegal ? RESP : ACC0;
      ACC0: if (ram_ack) state_nx = split ? ACC1 : RESP;
      ACC1: if (ram_ack) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture and load byte buffer (each ack fills its half).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_fault    <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_wdata    <= '0;
      rbuf       <= '0;
    end else begin
      if (accept) begin
        r_store    <= req_store;
        r_unsigned <= req_unsigned;
        r_fault    <= illegal;
        r_addr     <= req_address;
        r_len      <= req_length;
        r_wdata    <= req_wdata;
      end
      if (ram_ack && state == ACC0) rbuf[DATA_WIDTH-1:0]            <= ram_rdata;
      if (ram_ack && state == ACC1) rbuf[2*DATA_WIDTH-1:DATA_WIDTH] <= ram_rdata;
    end
  end

  // Lane alignment for stores and extraction/extension for loads.
  always_comb begin
    lmask = '0;
    wmask = '0;
    for (int i = 0; i < BYTES; i++) begin
      lmask[i]         = (LEN_W'(i) <= r_len);
      wmask[i*8 +: 8]  = {8{LEN_W'(i) <= r_len}};
    end
    wide_sel   = {{BYTES{1'b0}}, lmask} << r_off;
    wide_dat   = {{DATA_WIDTH{1'b0}}, r_wdata & wmask} << {r_off, 3'b000};
    shifted_lo = DATA_WIDTH'(rbuf >> {r_off, 3'b000});
    sign       = shifted_lo[{r_len, 3'b111}] & ~r_unsigned;
    ld_data    = '0;
    for (int i = 0; i < BYTES; i++)
      ld_data[i*8 +: 8] = lmask[i] ? shifted_lo[i*8 +: 8] : {8{sign}};
  end

  // Output decode from state and captured request.
  always_comb begin
    req_ready       = (state == IDLE);
    ram_req         = (state == ACC0) || (state == ACC1);
    ram_store       = ram_req && r_store;
    ram_address     = '0;
    ram_wdata       = '0;
    ram_byte_select = '0;
    if (state == ACC0) begin
      ram_address = word_addr;
      if (r_store) begin
        ram_wdata       = wide_dat[DATA_WIDTH-1:0];
        ram_byte_select = wide_sel[BYTES-1:0];
      end
    end else if (state == ACC1) begin
      ram_address = word_addr + ADDR_WIDTH'(BYTES);
      if (r_store) begin
        ram_wdata       = wide_dat[2*DATA_WIDTH-1:DATA_WIDTH];
        ram_byte_select = wide_sel[2*BYTES-1:BYTES];
      end
    end
    resp_valid = (state == RESP);
    resp_fault = resp_valid && r_fault;
    resp_rdata = (resp_valid && !r_fault && !r_store) ? ld_data : '0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: main instance with misaligned
// splitting enabled, second instance with it disabled.
module tb_mem_access_unit;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_valid1 = 0, req_store = 0, req_unsigned = 0;
  logic [31:0] req_address = 0, req_wdata = 0, ram_rdata = 0;
  logic [1:0]  req_length = 0;
  logic        ram_ack = 0;

  logic        req_ready, resp_valid, resp_fault, ram_req, ram_store;
  logic [31:0] resp_rdata, ram_address, ram_wdata;
  logic [3:0]  ram_byte_select;
  logic        m_req_ready, m_resp_valid, m_resp_fault, m_ram_req, m_ram_store;
  logic [31:0] m_resp_rdata, m_ram_address, m_ram_wdata;
  logic [3:0]  m_ram_byte_select;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGNED_EN(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_length(req_length), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_fault(resp_fault), .resp_rdata(resp_rdata), .ram_req(ram_req),
    .ram_store(ram_store), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_byte_select(ram_byte_select), .ram_ack(ram_ack), .ram_rdata(ram_rdata));

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGNED_EN(0)) dut_al (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(m_req_ready),
    .req_store(req_store), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_length(req_length), .req_wdata(req_wdata), .resp_valid(m_resp_valid),
    .resp_fault(m_resp_fault), .resp_rdata(m_resp_rdata), .ram_req(m_ram_req),
    .ram_store(m_ram_store), .ram_address(m_ram_address), .ram_wdata(m_ram_wdata),
    .ram_byte_select(m_ram_byte_select), .ram_ack(ram_ack), .ram_rdata(ram_rdata));

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t0 = 0, acks = 0, a0 = 0;

  always @(posedge clk) begin
    cyc++;
    if (ram_req && ram_ack) acks++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit which, input bit st, input bit uns, input logic [31:0] a,
                       input logic [1:0] len, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready", which ? m_req_ready : req_ready, 1);
    req_store = st; req_unsigned = uns; req_address = a; req_length = len; req_wdata = wd;
    if (which) req_valid1 = 1; else req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0; req_valid1 = 0;
    t0 = cyc; a0 = acks;
  endtask

  // Waits for a RAM request, records it, then acks after 'waits' extra cycles.
  task automatic serve(input int waits, input logic [31:0] rd, output logic [31:0] a,
                       output logic [3:0] sel, output logic [31:0] wd, output logic st);
    int k = 0;
    @(negedge clk);
    while (!ram_req && k < 20) begin @(negedge clk); k++; end
    if (!ram_req) chk("ram_req_timeout", 0, 1);
    a = ram_address; sel = ram_byte_select; wd = ram_wdata; st = ram_store;
    repeat (waits) @(negedge clk);
    ram_ack = 1; ram_rdata = rd;
    @(posedge clk);
    #1 ram_ack = 0; ram_rdata = 0;
  endtask

  task automatic wait_resp(input bit which, output int lat, output logic f, output logic [31:0] rd);
    lat = -1; f = 0; rd = 0;
    for (int k = 0; k < 30 && lat < 0; k++) begin
      @(negedge clk);
      if (which ? m_resp_valid : resp_valid) begin
        lat = cyc - t0 + 1;
        f   = which ? m_resp_fault : resp_fault;
        rd  = which ? m_resp_rdata : resp_rdata;
      end
    end
  endtask

  initial begin
    logic [31:0] a, wd, rd;
    logic [3:0]  sel;
    logic        st, f, seen;
    int          lat;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_ram_req", ram_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_sel", ram_byte_select, 0);
    chk("rst_rdata", resp_rdata, 0);
    reset = 0;

    // aligned word load, zero-wait
    issue(0, 0, 0, 32'h100, 2'd3, 32'h0);
    serve(0, 32'h8899AABB, a, sel, wd, st);
    chk("ldw_addr", a, 32'h100);
    chk("ldw_sel", sel, 4'b0000);
    chk("ldw_store", st, 0);
    wait_resp(0, lat, f, rd);
    chk("ldw_lat", lat, 2);
    chk("ldw_fault", f, 0);
    chk("ldw_rdata", rd, 32'h8899AABB);
    chk("ldw_nacc", acks - a0, 1);

    // byte store at 0x203 (upper wdata bits must not leak)
    issue(0, 1, 0, 32'h203, 2'd0, 32'h123456A5);
    serve(0, 32'hDEADBEEF, a, sel, wd, st);
    chk("stb_addr", a, 32'h200);
    chk("stb_sel", sel, 4'b1000);
    chk("stb_wdata", wd, 32'hA5000000);
    chk("stb_store", st, 1);
    wait_resp(0, lat, f, rd);
    chk("stb_lat", lat, 2);
    chk("stb_rdata", rd, 0);

    // signed / unsigned half load at 0x101, one wait cycle
    issue(0, 0, 0, 32'h101, 2'd1, 32'h0);
    serve(1, 32'h00F08000, a, sel, wd, st);
    chk("ldh_addr", a, 32'h100);
    wait_resp(0, lat, f, rd);
    chk("ldh_lat", lat, 3);
    chk("ldh_rdata", rd, 32'hFFFFF080);
    chk("ldh_nacc", acks - a0, 1);
    issue(0, 0, 1, 32'h101, 2'd1, 32'h0);
    serve(0, 32'h00F08000, a, sel, wd, st);
    wait_resp(0, lat, f, rd);
    chk("ldhu_rdata", rd, 32'h0000F080);

    // split word store at 0x0FE, two wait cycles per access
    issue(0, 1, 0, 32'h0FE, 2'd3, 32'h11223344);
    serve(2, 32'h0, a, sel, wd, st);
    chk("sts_a1_addr", a, 32'h0FC);
    chk("sts_a1_sel", sel, 4'b1100);
    chk("sts_a1_wdata", wd, 32'h33440000);
    serve(2, 32'h0, a, sel, wd, st);
    chk("sts_a2_addr", a, 32'h100);
    chk("sts_a2_sel", sel, 4'b0011);
    chk("sts_a2_wdata", wd, 32'h00001122);
    wait_resp(0, lat, f, rd);
    chk("sts_lat", lat, 7);
    chk("sts_nacc", acks - a0, 2);

    // split load: bytes from two words merged and sign-extended
    issue(0, 0, 0, 32'h2FF, 2'd1, 32'h0);
    serve(0, 32'h80AABBCC, a, sel, wd, st);
    serve(0, 32'h11223381, a, sel, wd, st);
    chk("lds_a2_addr", a, 32'h300);
    wait_resp(0, lat, f, rd);
    chk("lds_lat", lat, 3);
    chk("lds_rdata", rd, 32'hFFFF8180);

    // faults: misaligned word on strict instance, length 2 on both
    issue(1, 0, 0, 32'h102, 2'd3, 32'h0);
    wait_resp(1, lat, f, rd);
    chk("flt_mis_lat", lat, 1);
    chk("flt_mis_fault", f, 1);
    chk("flt_mis_rdata", rd, 0);
    chk("flt_mis_noram", m_ram_req, 0);
    issue(1, 0, 0, 32'h100, 2'd2, 32'h0);
    wait_resp(1, lat, f, rd);
    chk("flt_len_lat", lat, 1);
    chk("flt_len_fault", f, 1);
    a0 = acks;
    issue(0, 0, 0, 32'h100, 2'd2, 32'h0);
    wait_resp(0, lat, f, rd);
    chk("flt_len0_lat", lat, 1);
    chk("flt_len0_fault", f, 1);
    chk("flt_len0_nacc", acks - a0, 0);

    // wrapping split aborted by reset while in the second access
    issue(0, 0, 0, 32'hFFFFFFFE, 2'd3, 32'h0);
    serve(0, 32'h0, a, sel, wd, st);
    chk("wrap_a1_addr", a, 32'hFFFFFFFC);
    @(negedge clk);
    chk("wrap_a2_req", ram_req, 1);
    chk("wrap_a2_addr", ram_address, 32'h0);
    #1 reset = 1;
    #1;
    chk("abort_ram_req", ram_req, 0);
    chk("abort_resp", resp_valid, 0);
    @(negedge clk) reset = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen = 1; end
    chk("abort_no_resp", seen, 0);
    chk("abort_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
